// File: rtl/shift_reg_piso.sv
// Purpose: parallel-in, serial-out shift register with serial fill at the vacated end (MSB first;
//          LSB first when SHIFT_REG_PISO_LSB_FIRST_EN is defined).
// Latency: o_out shows the first bit of a loaded word one edge after the load; one bit per edge after that.
// Backpressure: none; the register shifts on every edge that is not a load, so the consumer samples every cycle.
module shift_reg_piso #(
   parameter int WIDTH = 8   // register length and load width, must be >= 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_wr_data_en,
   input  logic             i_wr_bit,
   output logic             o_out
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next state: a load replaces the contents outright, otherwise shift one place and take in the fill bit.
   always_comb begin
      q_d = q_q;
      if (i_wr_data_en) begin
         q_d = i_wr_data;
      end else begin
`ifdef SHIFT_REG_PISO_LSB_FIRST_EN
         q_d = {i_wr_bit, q_q[WIDTH-1:1]};
`else
         q_d = {q_q[WIDTH-2:0], i_wr_bit};
`endif
      end
   end

   // State register; reset clears it without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   // The serial line is the outgoing end of the register, straight from a flop.
`ifdef SHIFT_REG_PISO_LSB_FIRST_EN
   assign o_out = q_q[0];
`else
   assign o_out = q_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_shift_reg_piso.sv
// Bench for shift_reg_piso: a bit-queue reference model feeds an expected-output scoreboard,
// and a monitor compares o_out against it one time unit after every rising edge.
// Asynchronous reset behaviour is checked directly between edges.
module tb_shift_reg_piso;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] i_wr_data;
   logic         i_wr_data_en;
   logic         i_wr_bit;
   logic         o_out;

   int checks   = 0;
   int failures = 0;

   bit mdl[$];      // bits still to leave the register, front = the bit on o_out
   bit exp_q[$];    // scoreboard of expected o_out after each driven edge
   bit mon_en = 1'b0;

   shift_reg_piso #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_wr_data    (i_wr_data),
      .i_wr_data_en (i_wr_data_en),
      .i_wr_bit     (i_wr_bit),
      .o_out        (o_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: o_out=%0b expected=%0b at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model reset: the register holds all zeros.
   task automatic mdl_reset();
      mdl.delete();
      for (int i = 0; i < W; i++) mdl.push_back(1'b0);
   endtask

   // Drive one edge's worth of inputs and push the expected output that edge will produce.
   task automatic step(input logic en, input logic [W-1:0] d, input logic b);
      @(negedge clk);
      i_wr_data_en = en;
      i_wr_data    = d;
      i_wr_bit     = b;
      if (en) begin
         mdl.delete();
`ifdef SHIFT_REG_PISO_LSB_FIRST_EN
         for (int i = 0; i < W; i++) mdl.push_back(d[i]);
`else
         for (int i = W - 1; i >= 0; i--) mdl.push_back(d[i]);
`endif
      end else begin
         void'(mdl.pop_front());
         mdl.push_back(b);
      end
      exp_q.push_back(mdl[0]);
   endtask

   // Monitor: the output is valid for the whole cycle after each edge.
   always @(posedge clk) begin
      #1;
      if (rst_n && mon_en && exp_q.size() != 0) begin
         bit e;
         e = exp_q.pop_front();
         chk("sb_out", o_out, e);
      end
   end

   // Assert reset half way through a cycle, then release it mid-way through a later cycle.
   task automatic async_reset(input int hold_cycles);
      @(negedge clk);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("reset_immediate", o_out, 1'b0);
      for (int i = 0; i < hold_cycles; i++) begin
         @(negedge clk);
         chk("reset_held", o_out, 1'b0);
      end
      mdl_reset();
      exp_q.delete();
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   initial begin
      rst_n        = 1'b1;
      i_wr_data    = '0;
      i_wr_data_en = 1'b0;
      i_wr_bit     = 1'b0;
      mdl_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_initial", o_out, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Load and shift with zero fill, then one fill.
      step(1'b1, 8'b10100110, 1'b0);
      for (int i = 0; i < W + 2; i++) step(1'b0, '0, 1'b0);
      step(1'b1, 8'b10100110, 1'b1);
      for (int i = 0; i < W + 3; i++) step(1'b0, '0, 1'b1);

      // Reload mid-shift.
      step(1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      step(1'b1, 8'h00, 1'b1);
      step(1'b0, '0, 1'b0);

      // Serial delay: pattern on the fill input reappears W cycles later.
      step(1'b1, 8'h00, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      for (int i = 0; i < W + 2; i++) step(1'b0, '0, 1'b0);

      // Back-to-back loads.
      step(1'b1, 8'h80, 1'b0);
      step(1'b1, 8'h7F, 1'b0);
      step(1'b1, 8'hC3, 1'b1);
      step(1'b0, '0, 1'b0);

      // Reset while a word holding ones is mid-shift.
      step(1'b1, 8'hFF, 1'b1);
      step(1'b0, '0, 1'b1);
      async_reset(3);
      step(1'b0, '0, 1'b1);
      for (int i = 0; i < W; i++) step(1'b0, '0, 1'b0);

      // Random traffic with occasional loads.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom));
      end
      step(1'b0, '0, 1'b0);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: pending=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
